hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_pkg.sv | 6 +
 rtl/muldiv_timer.sv | 19 +
 rtl/hazard_unit.sv | 59 +++++
 tb/tb_hazard_unit.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared state encoding and constants for the pipeline hazard unit
package hazard_pkg;
  typedef enum logic {RUN, MD_BUSY} state_t;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int MD_LATENCY_DEF = 32;
endpackage

// File: rtl/muldiv_timer.sv
// muldiv_timer: loadable down-counter tracking remaining mul/div occupancy
module muldiv_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk) begin
    if (rst) r_cnt <= '0;
    else if (i_load) r_cnt <= i_load_val;
    else if (i_dec && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end
  assign o_zero = r_cnt == '0;
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: load-use, branch-flush and mul/div occupancy stall control
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rt,
  input  logic        id_muldiv,
  input  logic        id_mfhilo,
  input  logic        ex_memread,
  input  logic [4:0]  ex_wn,
  input  logic        ex_branch_taken,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        id_ex_bubble,
  output logic        if_id_flush,
  output logic        muldiv_start,
  output logic        muldiv_busy,
  output logic [15:0] stall_cycles
);
  state_t      r_state;
  logic [15:0] r_stall_cycles;
  logic        w_load_use, w_busy, w_stall, w_md_zero;
  assign w_load_use = ex_memread && ex_wn != REG_ZERO &&
                      (ex_wn == id_rs || (id_use_rt && ex_wn == id_rt));
  assign w_busy = r_state == MD_BUSY;
  // a taken branch flushes the wrong-path instruction, so no stall can apply
  assign w_stall = !rst && !ex_branch_taken &&
                   (w_load_use || (w_busy && (id_mfhilo || id_muldiv)));
  assign pc_write     = !w_stall;
  assign if_id_write  = !w_stall;
  assign id_ex_bubble = !rst && (ex_branch_taken || w_stall);
  assign if_id_flush  = !rst && ex_branch_taken;
  assign muldiv_start = !rst && !w_busy && id_muldiv && !w_load_use && !ex_branch_taken;
  assign muldiv_busy  = !rst && w_busy;
  assign stall_cycles = r_stall_cycles;
  muldiv_timer #(.W(8)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (muldiv_start),
    .i_load_val (8'(MD_LATENCY - 1)),
    .i_dec      (w_busy),
    .o_zero     (w_md_zero)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= RUN;
      r_stall_cycles <= '0;
    end else begin
      if (muldiv_start) r_state <= MD_BUSY;
      else if (w_busy && w_md_zero) r_state <= RUN;
      if (w_stall && r_stall_cycles != 16'hFFFF) r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: randomized and directed checks against a cycle-level reference model
module tb_hazard_unit;
  localparam int LAT = 32;
  logic clk = 0, rst;
  logic [4:0] id_rs, id_rt, ex_wn;
  logic id_use_rt, id_muldiv, id_mfhilo, ex_memread, ex_branch_taken;
  logic pc_write, if_id_write, id_ex_bubble, if_id_flush, muldiv_start, muldiv_busy;
  logic [15:0] stall_cycles;
  logic [5:0] got, exp_o;
  int checks = 0, errors = 0;
  int m_rem = 0, m_stall = 0;
  hazard_unit #(.MD_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rt(id_use_rt),
    .id_muldiv(id_muldiv), .id_mfhilo(id_mfhilo), .ex_memread(ex_memread), .ex_wn(ex_wn),
    .ex_branch_taken(ex_branch_taken), .pc_write(pc_write), .if_id_write(if_id_write),
    .id_ex_bubble(id_ex_bubble), .if_id_flush(if_id_flush), .muldiv_start(muldiv_start),
    .muldiv_busy(muldiv_busy), .stall_cycles(stall_cycles)
  );
  assign got = {pc_write, if_id_write, id_ex_bubble, if_id_flush, muldiv_start, muldiv_busy};
  always #5 clk = ~clk;
  task automatic idle();
    rst = 0; id_rs = 5'd1; id_rt = 5'd2; id_use_rt = 0; id_muldiv = 0; id_mfhilo = 0;
    ex_memread = 0; ex_wn = 5'd3; ex_branch_taken = 0;
  endtask
  // m_rem = busy cycles still to come; expected outputs derived from the rules directly
  task automatic settle();
    logic lu, stall, start;
    @(negedge clk);
    lu = ex_memread && ex_wn != 0 && (ex_wn == id_rs || (id_use_rt && ex_wn == id_rt));
    stall = !rst && !ex_branch_taken && (lu || (m_rem > 0 && (id_mfhilo || id_muldiv)));
    start = !rst && m_rem == 0 && id_muldiv && !lu && !ex_branch_taken;
    exp_o = {!stall, !stall, !rst && (ex_branch_taken || stall), !rst && ex_branch_taken,
             start, !rst && m_rem > 0};
  endtask
  task automatic advance();
    @(posedge clk);
    if (rst) begin
      m_rem = 0; m_stall = 0;
    end else begin
      if (!exp_o[5] && m_stall < 65535) m_stall++;
      if (m_rem > 0) m_rem--;
      else if (exp_o[1]) m_rem = LAT;
    end
    #1;
  endtask
  task automatic test_reset();
    idle(); rst = 1; ex_memread = 1; ex_wn = 5'd1; id_muldiv = 1; ex_branch_taken = 1;
    settle(); advance();
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++;
      if (got !== 6'b110000) begin errors++; $display("FAIL reset_out got %b want 110000", got); end
      checks++;
      if (stall_cycles !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", stall_cycles); end
      advance();
    end
    idle();
  endtask
  task automatic test_load_use();
    idle(); ex_memread = 1; ex_wn = 5'd8; id_rs = 5'd8;
    settle();
    checks++;
    if (got !== 6'b001000) begin errors++; $display("FAIL load_use_stall got %b want 001000", got); end
    advance(); idle(); settle();
    checks++;
    if (got !== 6'b110000) begin errors++; $display("FAIL load_use_release got %b want 110000", got); end
    checks++;
    if (stall_cycles !== 16'd1) begin errors++; $display("FAIL load_use_cnt got %0d want 1", stall_cycles); end
    advance();
    idle(); ex_memread = 1; ex_wn = 5'd9; id_rt = 5'd9; id_use_rt = 1;
    settle();
    checks++;
    if (got !== 6'b001000) begin errors++; $display("FAIL load_use_rt got %b want 001000", got); end
    advance(); idle();
  endtask
  task automatic test_zero_reg();
    logic [15:0] sc0;
    idle(); ex_memread = 1; ex_wn = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_use_rt = 1;
    settle(); sc0 = stall_cycles;
    checks++;
    if (got !== 6'b110000) begin errors++; $display("FAIL zero_reg got %b want 110000", got); end
    advance(); settle();
    checks++;
    if (stall_cycles !== sc0) begin errors++; $display("FAIL zero_reg_cnt got %0d want %0d", stall_cycles, sc0); end
    advance(); idle();
  endtask
  task automatic test_branch_priority();
    logic [15:0] sc0;
    idle(); ex_memread = 1; ex_wn = 5'd8; id_rs = 5'd8; ex_branch_taken = 1;
    settle(); sc0 = stall_cycles;
    checks++;
    if (got !== 6'b111100) begin errors++; $display("FAIL branch_prio got %b want 111100", got); end
    advance(); idle(); settle();
    checks++;
    if (stall_cycles !== sc0) begin errors++; $display("FAIL branch_cnt got %0d want %0d", stall_cycles, sc0); end
    advance();
  endtask
  task automatic test_muldiv();
    logic [5:0] e;
    idle(); id_muldiv = 1;
    for (int c = 0; c <= 33; c++) begin
      if (c == 1) id_muldiv = 0;
      if (c >= 5) id_mfhilo = 1;
      settle();
      e = {!(c >= 5 && c <= 32), !(c >= 5 && c <= 32), c >= 5 && c <= 32, 1'b0, c == 0, c >= 1 && c <= 32};
      checks++;
      if (got !== e) begin errors++; $display("FAIL muldiv_c%0d got %b want %b", c, got, e); end
      advance();
    end
    idle();
  endtask
  task automatic test_back_to_back();
    logic [5:0] e;
    idle(); id_muldiv = 1;
    for (int c = 0; c <= 33; c++) begin
      settle();
      e = (c == 0 || c == 33) ? 6'b110010 : 6'b001001;
      checks++;
      if (got !== e) begin errors++; $display("FAIL b2b_c%0d got %b want %b", c, got, e); end
      advance();
    end
    idle();
    // let the second operation drain so later tests start from RUN
    for (int c = 0; c < LAT; c++) begin settle(); advance(); end
  endtask
  task automatic test_reset_mid_busy();
    idle(); id_muldiv = 1; settle(); advance(); idle();
    for (int c = 1; c < 10; c++) begin settle(); advance(); end
    rst = 1; settle();
    checks++;
    if (got !== 6'b110000) begin errors++; $display("FAIL rst_busy_out got %b want 110000", got); end
    advance(); rst = 0; id_mfhilo = 1;
    for (int c = 0; c < 3; c++) begin
      settle();
      checks++;
      if (got !== 6'b110000) begin errors++; $display("FAIL rst_busy_after got %b want 110000", got); end
      advance();
    end
    idle();
  endtask
  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 199) == 0;
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      ex_wn = 5'($urandom_range(0, 3)); id_use_rt = 1'($urandom);
      ex_memread = 1'($urandom); ex_branch_taken = $urandom_range(0, 7) == 0;
      id_muldiv = $urandom_range(0, 5) == 0; id_mfhilo = $urandom_range(0, 3) == 0;
      settle();
      checks++;
      if (got !== exp_o) begin errors++; $display("FAIL rand_out i=%0d got %b want %b", i, got, exp_o); end
      checks++;
      if (stall_cycles !== 16'(m_stall)) begin errors++; $display("FAIL rand_cnt i=%0d got %0d want %0d", i, stall_cycles, m_stall); end
      advance();
    end
    idle();
  endtask
  task automatic test_saturation();
    idle(); rst = 1; settle(); advance(); idle();
    ex_memread = 1; ex_wn = 5'd4; id_rs = 5'd4;
    settle();
    repeat (70000) advance();
    settle();
    checks++;
    if (stall_cycles !== 16'hFFFF) begin errors++; $display("FAIL sat_cnt got %h want ffff", stall_cycles); end
    advance(); idle(); settle();
    checks++;
    if (stall_cycles !== 16'hFFFF || got !== 6'b110000) begin
      errors++; $display("FAIL sat_hold got %h/%b want ffff/110000", stall_cycles, got);
    end
    advance();
  endtask
  initial begin
    test_reset();
    test_load_use();
    test_zero_reg();
    test_branch_priority();
    test_muldiv();
    test_back_to_back();
    test_reset_mid_busy();
    test_random();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
